// File: rtl/cpu_step_ctrl.sv
// cpu_step_ctrl: synchronised, debounced run/step front panel issuing the CPU advance strobe
module cpu_step_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W = 20
) (
    input  logic        clk,
    input  logic        reset_cpu_n,
    input  logic        button,
    input  logic        start,
    input  logic        enable,
    output logic        cpu_step,
    output logic        running,
    output logic        btn_level,
    output logic [15:0] step_count
);
    typedef enum logic [2:0] {IDLE, WAIT, PULSE, RELEASE, RUN} state_t;
    state_t state, state_nx;
    logic [1:0] btn_q, start_q, en_q;
    logic [CNT_W-1:0] db_cnt;
    logic btn_s, start_s, en_s, db_done;
    assign btn_s   = btn_q[1];
    assign start_s = start_q[1];
    assign en_s    = en_q[1];
    assign db_done = btn_s != btn_level && db_cnt == CNT_W'(DEBOUNCE_CYCLES - 1);
    always_ff @(posedge clk or negedge reset_cpu_n) begin
        if (!reset_cpu_n) begin
            btn_q     <= '0;
            start_q   <= '0;
            en_q      <= '0;
            db_cnt    <= '0;
            btn_level <= 1'b0;
        end else begin
            btn_q     <= {btn_q[0], button};
            start_q   <= {start_q[0], start};
            en_q      <= {en_q[0], enable};
            db_cnt    <= (btn_s == btn_level || db_done) ? '0 : db_cnt + CNT_W'(1);
            btn_level <= db_done ? ~btn_level : btn_level;
        end
    end
    // Mode select outranks the button in WAIT; PULSE always completes
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start_s ? WAIT : IDLE;
            WAIT:    state_nx = !start_s ? IDLE : !en_s ? RUN : btn_level ? PULSE : WAIT;
            PULSE:   state_nx = RELEASE;
            RELEASE: state_nx = !start_s ? IDLE : !btn_level ? WAIT : RELEASE;
            RUN:     state_nx = !start_s ? IDLE : en_s ? RELEASE : RUN;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset_cpu_n) begin
        if (!reset_cpu_n) begin
            state      <= IDLE;
            cpu_step   <= 1'b0;
            running    <= 1'b0;
            step_count <= '0;
        end else begin
            state      <= state_nx;
            cpu_step   <= state_nx == PULSE || state_nx == RUN;
            running    <= state_nx == RUN;
            step_count <= step_count + 16'(cpu_step);
        end
    end
endmodule
